// File: rtl/image_ram_arb_pkg.sv
// rtl/image_ram_arb_pkg.sv - shared types and default widths for the image RAM arbiter
package image_ram_arb_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    OWN_IDLE    = 2'd0,
    OWN_DISP    = 2'd1,
    OWN_PROC_RD = 2'd2,
    OWN_PROC_WR = 2'd3
  } owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - saturating count of cycles the processing engine has been refused
module arb_wait_counter #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  assign at_max = (cnt == MAX_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/image_ram_arbiter.sv
// rtl/image_ram_arbiter.sv - single-port image RAM arbiter, display priority, optional STARVE_GUARD_EN
// Read data is returned one cycle after the grant, steered by the registered owner.
module image_ram_arbiter
  import image_ram_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_stall,
  input  logic              proc_req,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic              proc_gnt,
  output logic              proc_rvalid,
  output logic [DATA_W-1:0] proc_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  owner_e            owner;
  owner_e            last_owner;
  logic              force_proc;
  logic [DATA_W-1:0] disp_hold;
  logic [DATA_W-1:0] proc_hold;

`ifdef STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_at_max;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait_counter (
    .clk    (clk),
    .reset  (reset),
    .inc    (proc_req && !proc_gnt),
    .clr    (!proc_req || proc_gnt),
    .cnt    (wait_cnt),
    .at_max (wait_at_max)
  );

  assign force_proc = proc_req && wait_at_max;
`else
  assign force_proc = 1'b0;
`endif

  always_comb begin
    owner      = OWN_IDLE;
    ram_addr   = '0;
    ram_data   = '0;
    ram_wren   = 1'b0;
    proc_gnt   = 1'b0;
    disp_stall = 1'b0;
    if (force_proc || (proc_req && !disp_req)) begin
      owner      = proc_we ? OWN_PROC_WR : OWN_PROC_RD;
      ram_addr   = proc_addr;
      ram_data   = proc_wdata;
      ram_wren   = proc_we;
      proc_gnt   = 1'b1;
      disp_stall = force_proc && disp_req;
    end else if (disp_req) begin
      owner    = OWN_DISP;
      ram_addr = disp_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner <= OWN_IDLE;
      disp_hold  <= '0;
      proc_hold  <= '0;
    end else begin
      last_owner <= owner;
      if (last_owner == OWN_DISP) disp_hold <= ram_q;
      if (last_owner == OWN_PROC_RD) proc_hold <= ram_q;
    end
  end

  // Data passes straight through in the return cycle and is held afterwards.
  assign disp_valid  = (last_owner == OWN_DISP);
  assign proc_rvalid = (last_owner == OWN_PROC_RD);
  assign disp_data   = disp_valid  ? ram_q : disp_hold;
  assign proc_rdata  = proc_rvalid ? ram_q : proc_hold;

endmodule

// File: tb/tb_image_ram_arbiter.sv
// tb/tb_image_ram_arbiter.sv - directed bench with RAM model and behavioural scoreboard, STARVE_GUARD_EN aware
module tb_image_ram_arbiter;

  localparam int MAX_WAIT = 15;
`ifdef STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_stall;
  logic        proc_req;
  logic        proc_we;
  logic [15:0] proc_addr;
  logic [7:0]  proc_wdata;
  logic        proc_gnt;
  logic        proc_rvalid;
  logic [7:0]  proc_rdata;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic [7:0]  ram_q;

  int errors = 0;
  int checks = 0;

  image_ram_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid),
    .disp_data(disp_data), .disp_stall(disp_stall),
    .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_gnt(proc_gnt), .proc_rvalid(proc_rvalid),
    .proc_rdata(proc_rdata), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM: registered read, returns old contents on a same-cycle write.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  // Scoreboard: image contents plus what each requester must see next cycle.
  logic [7:0] exp_mem [0:65535];
  int         m_wait;
  logic       m_dv, m_pv;
  logic [7:0] m_dd, m_pd;

  function automatic logic [7:0] init_pix(int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  function automatic int who(logic dr, logic pr, int w);
    if (GUARD && pr && w == MAX_WAIT) return 2;
    if (dr) return 1;
    if (pr) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_wait = 0; m_dv = 0; m_pv = 0; m_dd = 0; m_pd = 0;
    end else begin
      int o;
      o = who(disp_req, proc_req, m_wait);
      m_dv = (o == 1);
      m_pv = (o == 2) && !proc_we;
      if (m_dv) m_dd = exp_mem[disp_addr];
      if (m_pv) m_pd = exp_mem[proc_addr];
      if (o == 2 && proc_we) exp_mem[proc_addr] = proc_wdata;
      if (GUARD && proc_req && o != 2) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else m_wait = 0;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int o;
    o = who(disp_req, proc_req, m_wait);
    check("sb_ram_addr", 32'(ram_addr), o == 1 ? 32'(disp_addr) : o == 2 ? 32'(proc_addr) : 0);
    check("sb_ram_wren", 32'(ram_wren), 32'(o == 2 && proc_we));
    check("sb_ram_data", 32'(ram_data), o == 2 ? 32'(proc_wdata) : 0);
    check("sb_proc_gnt", 32'(proc_gnt), 32'(o == 2));
    check("sb_disp_stall", 32'(disp_stall), 32'(o == 2 && disp_req));
    check("sb_disp_valid", 32'(disp_valid), 32'(m_dv));
    check("sb_disp_data", 32'(disp_data), 32'(m_dd));
    check("sb_proc_rvalid", 32'(proc_rvalid), 32'(m_pv));
    check("sb_proc_rdata", 32'(proc_rdata), 32'(m_pd));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req = 0; disp_addr = 0; proc_req = 0; proc_we = 0; proc_addr = 0; proc_wdata = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] lit2 [4];
    int n;
    lit2[0] = 8'h03; lit2[1] = 8'h0A; lit2[2] = 8'h11; lit2[3] = 8'h18;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = init_pix(i);
      exp_mem[i] = init_pix(i);
    end
    ram_q = 0;
    reset = 0;
    idle_inputs();
    step(); step();
    reset = 1;
    step();
    check("rst_disp_valid", 32'(disp_valid), 0);
    check("rst_proc_rvalid", 32'(proc_rvalid), 0);
    check("rst_disp_data", 32'(disp_data), 0);
    check("rst_proc_rdata", 32'(proc_rdata), 0);
    check("rst_disp_stall", 32'(disp_stall), 0);

    // 1: read captured, then reset hits before the data is consumed
    disp_req = 1; disp_addr = 16'h0100;
    step();
    reset = 0; disp_req = 0; disp_addr = 0;
    #1;
    check("t1_valid_in_reset", 32'(disp_valid), 0);
    check("t1_data_in_reset", 32'(disp_data), 0);
    step(); step();
    reset = 1;
    step();
    check("t1_no_valid_after", 32'(disp_valid), 0);
    check("t1_data_zero", 32'(disp_data), 0);

    // 2: display reads 0..3
    for (int a = 0; a < 4; a++) begin
      disp_req = 1; disp_addr = 16'(a);
      step();
      check("t2_disp_valid", 32'(disp_valid), 1);
      check("t2_disp_data", 32'(disp_data), 32'(lit2[a]));
    end
    idle_inputs();
    step();
    check("t2_valid_drop", 32'(disp_valid), 0);
    check("t2_data_hold", 32'(disp_data), 32'h18);

    // 3: write then read same address
    proc_req = 1; proc_we = 1; proc_addr = 16'h1234; proc_wdata = 8'hA5;
    #1;
    check("t3_wr_gnt", 32'(proc_gnt), 1);
    check("t3_wr_wren", 32'(ram_wren), 1);
    step();
    proc_we = 0; proc_wdata = 0;
    #1;
    check("t3_rd_gnt", 32'(proc_gnt), 1);
    check("t3_no_rvalid_after_wr", 32'(proc_rvalid), 0);
    step();
    idle_inputs();
    #1;
    check("t3_rvalid", 32'(proc_rvalid), 1);
    check("t3_rdata", 32'(proc_rdata), 32'hA5);
    step();

    // 4: contention, display wins
    disp_req = 1; disp_addr = 16'h0005;
    proc_req = 1; proc_we = 0; proc_addr = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_gnt_low", 32'(proc_gnt), 0);
      step();
      check("t4_disp_valid", 32'(disp_valid), 1);
      check("t4_disp_data", 32'(disp_data), 32'h26);
    end
    disp_req = 0;
    #1;
    check("t4_gnt_after_drop", 32'(proc_gnt), 1);
    step();
    idle_inputs();
    #1;
    check("t4_rvalid", 32'(proc_rvalid), 1);
    check("t4_rdata", 32'(proc_rdata), 32'h73);
    step();

`ifdef STARVE_GUARD_EN
    // 5: starvation guard forces a proc slot on the 16th cycle
    disp_req = 1; disp_addr = 16'h0002;
    proc_req = 1; proc_we = 0; proc_addr = 16'h0020;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (proc_gnt) begin
        n = i;
        break;
      end
      step();
    end
    check("t5_gnt_cycle", 32'(n), 16);
    check("t5_stall", 32'(disp_stall), 1);
    check("t5_ram_addr", 32'(ram_addr), 32'h0020);
    step();
    check("t5_no_disp_valid", 32'(disp_valid), 0);
    check("t5_rvalid", 32'(proc_rvalid), 1);
    check("t5_rdata", 32'(proc_rdata), 32'hE3);
    check("t5_wait_cleared_gnt", 32'(proc_gnt), 0);
    check("t5_wait_cleared_stall", 32'(disp_stall), 0);
    idle_inputs();
    step(); step();
`else
    n = 0;
`endif

    // 6: idle
    idle_inputs();
    step();
    check("t6_wren", 32'(ram_wren), 0);
    check("t6_addr", 32'(ram_addr), 0);
    check("t6_data", 32'(ram_data), 0);
    step();
    check("t6_disp_valid", 32'(disp_valid), 0);
    check("t6_proc_rvalid", 32'(proc_rvalid), 0);
    check("t6_stall", 32'(disp_stall), 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
